multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: replaces per-instruction combinational decode with a

---
 rtl/multicycle_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXECUTE/MEM/WB sequencer for a multi-cycle RV32I core
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       opcode_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_sel_o,
  output logic             branch_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       cause_q, cause_d, alu_op_q, alu_op_d, wb_sel_q, wb_sel_d;
  logic imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic pc_write_q, pc_write_d, pc_sel_q, pc_sel_d, branch_q, branch_d;
  logic alu_src_q, alu_src_d, reg_write_q, reg_write_d, trap_q, trap_d;
  logic fetch_ok, mem_ok, retire, limit, alu_act, d_ld, d_st, d_br, d_jmp;
  assign fetch_ok = imem_req_q & imem_ready_i;
  assign mem_ok   = dmem_req_q & dmem_ready_i;
  assign limit    = cnt_q == TW'(TIMEOUT - 1);
  // next state, wait counter, retire count and next-cycle registered outputs
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_ok) state_d = S_DECODE;
        else if (imem_req_q && limit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else if (imem_req_q) cnt_d = cnt_q + TW'(1);
      end
      S_DECODE: begin
        op_d    = opcode_i;
        state_d = opcode_i inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR} ? S_EXEC : S_TRAP;
        cause_d = state_d == S_TRAP ? 2'b01 : cause_q;
      end
      S_EXEC: begin
        state_d = op_q == OP_BR ? S_FETCH : (op_q == OP_LD || op_q == OP_ST) ? S_MEM : S_WB;
        retire  = op_q == OP_BR;
      end
      S_MEM: begin
        if (mem_ok) begin
          state_d = op_q == OP_ST ? S_FETCH : S_WB;
          retire  = op_q == OP_ST;
        end else if (limit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = state_q;
    endcase
    cnt_d       = state_d != state_q ? '0 : cnt_d;
    instret_d   = retire ? instret_q + CNT_W'(1) : instret_q;
    d_ld        = op_d == OP_LD;
    d_st        = op_d == OP_ST;
    d_br        = op_d == OP_BR;
    d_jmp       = op_d == OP_JAL || op_d == OP_JALR;
    alu_act     = state_d inside {S_EXEC, S_MEM, S_WB};
    imem_req_d  = state_d == S_FETCH;
    dmem_req_d  = state_d == S_MEM;
    dmem_we_d   = state_d == S_MEM && d_st;
    pc_write_d  = state_d == S_EXEC && d_jmp;
    pc_sel_d    = state_d == S_EXEC && (d_jmp || d_br);
    branch_d    = state_d == S_EXEC && d_br;
    alu_op_d    = !alu_act ? 2'b00 : (d_ld || d_st || d_jmp) ? 2'b00 : d_br ? 2'b01 : 2'b10;
    alu_src_d   = alu_act && (d_ld || d_st || op_d == OP_I || op_d == OP_JALR);
    reg_write_d = state_d == S_WB;
    wb_sel_d    = state_d != S_WB ? 2'b00 : d_ld ? 2'b01 : d_jmp ? 2'b10 : 2'b00;
    trap_d      = state_d == S_TRAP;
  end
  // all state and registered outputs; reset aborts any in-flight instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      cnt_q       <= '0;
      instret_q   <= '0;
      cause_q     <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      pc_write_q  <= 1'b0;
      pc_sel_q    <= 1'b0;
      branch_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= '0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      instret_q   <= instret_d;
      cause_q     <= cause_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      pc_write_q  <= pc_write_d;
      pc_sel_q    <= pc_sel_d;
      branch_q    <= branch_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      trap_q      <= trap_d;
    end
  end
  assign imem_req_o   = imem_req_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign ir_write_o   = fetch_ok;
  assign pc_write_o   = pc_write_q | fetch_ok;
  assign pc_sel_o     = pc_sel_q;
  assign branch_o     = branch_q;
  assign alu_src_o    = alu_src_q;
  assign alu_op_o     = alu_op_q;
  assign reg_write_o  = reg_write_q;
  assign wb_sel_o     = wb_sel_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl_fsm;
  localparam int TO = 4;
  localparam int CW = 3;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  logic clk = 0, rst_n = 0, imem_ready = 0, dmem_ready = 0;
  logic [6:0] opcode = '0;
  logic imem_req_o, dmem_req_o, dmem_we_o, ir_write_o, pc_write_o, pc_sel_o, branch_o;
  logic alu_src_o, reg_write_o, trap_o;
  logic [1:0] alu_op_o, wb_sel_o, trap_cause_o;
  logic [CW-1:0] instret_o;
  int total = 0, bad = 0;
  logic [CW-1:0] model_ir = '0;
  typedef struct {
    int endc, trapc, irw, irc, pcw, regw, dreq, brn, brc;
    logic [1:0] cause, wbsel;
    logic dwe, trap;
    logic [CW-1:0] instret;
  } exp_t;
  exp_t sb[$];

  multicycle_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .imem_ready_i(imem_ready),
    .dmem_ready_i(dmem_ready), .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_sel_o(pc_sel_o), .branch_o(branch_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
    .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input int iw, input int dw, input logic [CW-1:0] ir);
    exp_t e;
    logic ld, st, br, jmp, legal;
    int f;
    e = '{default: 0};
    ld = op == LD;
    st = op == ST;
    br = op == BR;
    jmp = op == JAL || op == JALR;
    legal = ld || st || br || jmp || op == R || op == I;
    e.instret = ir;
    if (iw >= TO) begin
      e.trapc = TO + 1; e.cause = 2; e.trap = 1;
      return e;
    end
    f = 1 + iw;
    e.irw = 1; e.irc = f; e.pcw = 1;
    if (!legal) begin
      e.trapc = f + 2; e.cause = 1; e.trap = 1;
      return e;
    end
    if ((ld || st) && dw >= TO) begin
      e.trapc = f + 2 + TO + 1; e.cause = 3; e.trap = 1; e.dreq = TO; e.dwe = st;
      return e;
    end
    e.dreq = (ld || st) ? 1 + dw : 0;
    e.dwe = st;
    e.brn = br ? 1 : 0;
    e.brc = f + 2;
    e.regw = (st || br) ? 0 : 1;
    e.wbsel = ld ? 2'b01 : jmp ? 2'b10 : 2'b00;
    e.pcw = jmp ? 2 : 1;
    e.endc = f + 3 + e.dreq + e.regw;
    e.instret = ir + 1'b1;
    return e;
  endfunction

  // called at posedge+1 of a cycle where the FSM sits in FETCH
  task automatic run(input string nm, input logic [6:0] op, input int iw, input int dw, input bit noise);
    exp_t e;
    int endc = 0, trapc = 0, irw = 0, irc = 0, pcw = 0, regw = 0, dreq = 0, brn = 0, brc = 0;
    int iwc = 0, dwc = 0;
    logic [1:0] wbsel = 0, brop = 0;
    logic dwe = 0, brsel = 0;
    logic [2:0] dalu = 0;
    e = model(op, iw, dw, model_ir);
    sb.push_back(e);
    if (!e.trap) model_ir = e.instret;
    opcode = op;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1 && imem_req_o && irw > 0) begin endc = c; break; end
      if (trap_o) begin trapc = c; break; end
      imem_ready = noise | (imem_req_o && iwc >= iw);
      if (imem_req_o) iwc++;
      dmem_ready = noise | (dmem_req_o && dwc >= dw);
      if (dmem_req_o) dwc++;
      #1;
      if (ir_write_o) begin irw++; irc = c; end
      if (pc_write_o) pcw++;
      if (reg_write_o) begin regw++; wbsel = wb_sel_o; end
      if (dmem_req_o) begin dreq++; dwe |= dmem_we_o; dalu = {alu_op_o, alu_src_o}; end
      if (branch_o) begin brn++; brc = c; brop = alu_op_o; brsel = pc_sel_o; end
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    chk({nm, ".end"}, endc, e.endc);
    chk({nm, ".trapcyc"}, trapc, e.trapc);
    chk({nm, ".trap"}, trap_o, e.trap);
    chk({nm, ".cause"}, trap_cause_o, e.cause);
    chk({nm, ".irw"}, irw, e.irw);
    if (e.irw > 0) chk({nm, ".ircyc"}, irc, e.irc);
    chk({nm, ".pcw"}, pcw, e.pcw);
    chk({nm, ".regw"}, regw, e.regw);
    if (e.regw > 0) chk({nm, ".wbsel"}, wbsel, e.wbsel);
    chk({nm, ".dreq"}, dreq, e.dreq);
    if (e.dreq > 0) begin
      chk({nm, ".dwe"}, dwe, e.dwe);
      chk({nm, ".memalu"}, dalu, 3'b001);
    end
    chk({nm, ".brn"}, brn, e.brn);
    if (e.brn > 0) begin
      chk({nm, ".brcyc"}, brc, e.brc);
      chk({nm, ".brop"}, brop, 2'b01);
      chk({nm, ".brsel"}, brsel, 1'b1);
    end
    chk({nm, ".instret"}, instret_o, e.instret);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #12;
    rst_n = 1;
    model_ir = '0;
    @(posedge clk); #1;
  endtask

  task automatic frozen(input string nm);
    logic act = 0;
    for (int c = 0; c < 6; c++) begin
      imem_ready = 1; dmem_ready = 1;
      #1;
      act |= imem_req_o | dmem_req_o | reg_write_o | ir_write_o | pc_write_o | branch_o;
      @(posedge clk); #1;
    end
    chk({nm, ".quiet"}, act, 1'b0);
    chk({nm, ".stuck"}, trap_o, 1'b1);
    chk({nm, ".irfrz"}, instret_o, model_ir);
  endtask

  initial begin
    logic seen;
    imem_ready = 1;
    dmem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.imem_req", imem_req_o, 1'b0);
    chk("rst.ir_write", ir_write_o, 1'b0);
    chk("rst.instret", instret_o, '0);
    chk("rst.trap", trap_o, 1'b0);
    chk("rst.alu_op", alu_op_o, 2'b00);
    rst_n = 1;
    #2;
    chk("rel.ir_write", ir_write_o, 1'b0);
    @(posedge clk); #1;
    chk("rel.imem_req", imem_req_o, 1'b1);
    run("r", R, 0, 0, 0);
    run("ld", LD, 0, 3, 0);
    run("st", ST, 0, 0, 0);
    run("br", BR, 0, 0, 0);
    run("i", I, 2, 0, 0);
    run("jal", JAL, 0, 0, 1);
    run("jalr", JALR, 0, 0, 0);
    run("wrap", R, 0, 0, 0);
    run("post", R, 0, 0, 0);
    opcode = LD;
    imem_ready = 1;
    dmem_ready = 0;
    for (int c = 0; c < 10 && !dmem_req_o; c++) begin
      @(posedge clk); #1;
    end
    chk("mid.dreq", dmem_req_o, 1'b1);
    @(posedge clk); #1;
    dmem_ready = 1;
    #1;
    rst_n = 0;
    #1;
    chk("mid.dreq0", dmem_req_o, 1'b0);
    chk("mid.instret", instret_o, '0);
    chk("mid.alu_src", alu_src_o, 1'b0);
    seen = reg_write_o;
    @(posedge clk); #1;
    seen |= reg_write_o;
    @(posedge clk); #3;
    rst_n = 1;
    model_ir = '0;
    #1;
    seen |= reg_write_o;
    @(posedge clk); #1;
    seen |= reg_write_o;
    chk("mid.regw", seen, 1'b0);
    chk("mid.imem_req", imem_req_o, 1'b1);
    run("r4", R, 0, 0, 0);
    run("ill", 7'b1111111, 0, 0, 0);
    frozen("ill");
    do_reset();
    run("dto", LD, 0, 100, 0);
    frozen("dto");
    do_reset();
    run("ito", R, 100, 0, 0);
    frozen("ito");
    do_reset();
    run("st4", ST, 0, 3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
